vid_to_axis: RTL and testbench
==============================

# vid_to_axis

Front-end converter that turns a parallel video-timing input (data, data-enable, vsync) into the pixel-clock AXI4-Stream video format used throughout the image pipeline (tdata/tuser/tlast/tvalid, no tready). It sits directly upstream of the line-regrouping stage. It marks start-of-frame with tuser on the first active pixel after vsync and end-of-line with tlast on the last pixel of each data-enable run. It also polices frame geometry against the configured image size.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- IMG_WIDTH, 640, expected active pixels per line (1..4095)
- IMG_HEIGHT, 480, expected active lines per frame (1..4095)
- VSYNC_POL, 1, active level of vid_vsync

- pixel_clk  in  1  sole clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- vid_data  in  DATA_WIDTH  pixel data, valid when vid_de=1
- vid_de  in  1  active-video enable
- vid_vsync  in  1  vertical sync, polarity per VSYNC_POL
- m_axis_tdata  out  DATA_WIDTH  pixel out
- m_axis_tvalid  out  1  pixel qualifier
- m_axis_tuser  out  1  first pixel of frame
- m_axis_tlast  out  1  last pixel of line
- width_err  out  1  sticky: a forwarded line length != IMG_WIDTH
- height_err  out  1  sticky: frame line count != IMG_HEIGHT, or vsync during de

## Operation
- Stage 1 registers vid_data, vid_de and vsync (normalised to active-high vs = vid_vsync ^ ~VSYNC_POL) every cycle.
- vs_rise = vs & ~vs_d1, using one extra vsync register.
- FSM states: IDLE, SOF, LINE, DROP.
  - IDLE: reset state; outputs never valid; vs_rise -> SOF. Mid-frame pixels after reset are discarded.
  - SOF: first stage-1 pixel with de=1 is emitted with tuser=1; -> LINE.
  - LINE: every stage-1 pixel with de=1 is emitted.
  - End of line: tlast=1 when stage-1 de=1 and current vid_de=0.
  - On tlast, line_cnt increments. If it reaches IMG_HEIGHT, -> DROP.
  - DROP: pixels discarded (tvalid=0) until vs_rise -> SOF.
- vs_rise in LINE or DROP: -> SOF. If line_cnt != IMG_HEIGHT at that point, set height_err.
- vs_rise while stage-1 de=1: the pixel is still emitted with tlast=1, height_err is set, and the next frame starts in SOF.
- Line pixel counter (12 bits):
  - Clears on each tlast and on vs_rise.
  - Saturates at 4095.
  - On tlast, if count+1 != IMG_WIDTH, set width_err.
  - Lines are never truncated or padded.
- line_cnt (12 bits) clears on vs_rise.
- Sticky errors clear only on reset.
- tdata is forwarded unmodified. It is held at its last value when tvalid=0.

## Timing
- Latency: vid_* sampled at edge k appears on m_axis_* after edge k+1, i.e. 2 cycles input-to-output. Output is fully registered.
- tlast needs one-pixel lookahead: it is decided from the stage-1 pixel and the live vid_de.
- Single-pixel line (de high one cycle): tvalid, tlast both 1 on that beat. If it is the first line of the frame, tuser is also 1.
- Back-to-back de runs separated by one idle cycle produce two distinct tlast beats.
- Reset (asynchronous, any time): all outputs 0, FSM IDLE, counters and errors 0. After release, the block waits for a fresh vs_rise.
- Throughput: 1 pixel/cycle, no backpressure.

## Configuration
- VID_TO_AXIS_STATUS_EN defined:
  - Adds outputs meas_width[11:0] and meas_height[11:0], both resetting to 0.
  - meas_width holds the length of the last completed line; meas_height holds the line count of the last completed frame.
  - Both update on tlast and vs_rise respectively.
- Undefined: ports absent, no measurement registers. width_err and height_err behave identically in both builds.

## Structure
- Shared package img_pkg:
  - FSM state encoding (IDLE/SOF/LINE/DROP)
  - 12-bit counter width constant
  - 4095 saturation constant
- Sub-module vid_sync_edge: one-register vsync polarity normaliser and rising-edge detector, reusable by other video front-ends.
- All else in vid_to_axis.

## Test plan
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=3 unless stated.
- Nominal frame, VSYNC_POL=1: vsync pulse, then 3 lines of 4 de cycles with 2-cycle gaps -> 12 beats; tuser only on beat 0; tlast on beats 3, 7, 11; errors 0; first beat 2 cycles after first de.
- Pixels before first vsync after reset -> tvalid stays 0 until the post-vsync first de.
- Short line of 3 pixels -> tlast on its 3rd pixel, width_err=1 and stays set through the next good frame.
- 4 lines in a frame -> 4th line dropped (tvalid=0); height_err=0. Then 2-line frame followed by vsync -> height_err=1.
- vsync rising mid-line at pixel 2 -> that pixel carries tlast; height_err=1; next de pixel carries tuser.
- rst_n pulsed low mid-line -> all outputs 0 asynchronously; no output until next vsync. With VID_TO_AXIS_STATUS_EN, meas_width=4 and meas_height=3 after a nominal frame.

Source files
------------

// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared video front-end FSM encoding and counter constants
package img_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SOF  = 2'd1,
    ST_LINE = 2'd2,
    ST_DROP = 2'd3
  } vid_state_e;

  localparam int               CNT_W   = 12;
  localparam logic [CNT_W-1:0] CNT_MAX = 12'd4095;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/vid_sync_edge.sv
// rtl/vid_sync_edge.sv - vsync polarity normaliser and rising-edge detector
module vid_sync_edge #(
  parameter logic POL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vsync_i,
  output logic rise_o
);

  logic vs_q;
  logic vs_d1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vs_q    <= 1'b0;
      vs_d1_q <= 1'b0;
    end else begin
      vs_q    <= vsync_i ^ ~POL;
      vs_d1_q <= vs_q;
    end
  end

  // rise is aligned with the stage-1 pixel sampled alongside vs_q
  assign rise_o = vs_q & ~vs_d1_q;

endmodule

// File: rtl/vid_to_axis.sv
// rtl/vid_to_axis.sv - parallel video timing to AXI4-Stream video with geometry checks
// Optional VID_TO_AXIS_STATUS_EN adds meas_width/meas_height outputs.
module vid_to_axis
  import img_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter int   IMG_WIDTH  = 640,
  parameter int   IMG_HEIGHT = 480,
  parameter logic VSYNC_POL  = 1'b1
) (
  input  logic                  pixel_clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] vid_data,
  input  logic                  vid_de,
  input  logic                  vid_vsync,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  width_err,
  output logic                  height_err
`ifdef VID_TO_AXIS_STATUS_EN
  ,
  output logic [CNT_W-1:0]      meas_width,
  output logic [CNT_W-1:0]      meas_height
`endif
);

  localparam logic [CNT_W:0]   WIDTH_C  = (CNT_W+1)'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] HEIGHT_C = CNT_W'(IMG_HEIGHT);

  vid_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_s1_q;
  logic                  de_s1_q;
  logic                  vs_rise;
  logic [CNT_W-1:0]      pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]      line_cnt_q, line_cnt_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tuser_q, tuser_d;
  logic                  tlast_q, tlast_d;
  logic                  werr_q, werr_d;
  logic                  herr_q, herr_d;
  logic                  emit;
  logic                  eol;
  logic [CNT_W-1:0]      line_inc;

  vid_sync_edge #(.POL(VSYNC_POL)) u_sync (
    .clk_i   (pixel_clk),
    .rst_ni  (rst_n),
    .vsync_i (vid_vsync),
    .rise_o  (vs_rise)
  );

  // end of line needs one pixel of lookahead: stage-1 de against live vid_de
  assign emit     = de_s1_q && ((state_q == ST_SOF) || (state_q == ST_LINE));
  assign eol      = emit && (!vid_de || vs_rise);
  assign line_inc = sat_inc(line_cnt_q);

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    tdata_d    = tdata_q;
    tvalid_d   = 1'b0;
    tuser_d    = 1'b0;
    tlast_d    = 1'b0;
    werr_d     = werr_q;
    herr_d     = herr_q;

    if (emit) begin
      tvalid_d  = 1'b1;
      tdata_d   = data_s1_q;
      tuser_d   = (state_q == ST_SOF);
      tlast_d   = eol;
      pix_cnt_d = sat_inc(pix_cnt_q);
    end

    case (state_q)
      ST_SOF:  if (emit) state_d = ST_LINE;
      default: ;
    endcase

    if (eol) begin
      pix_cnt_d  = '0;
      line_cnt_d = line_inc;
      if (({1'b0, pix_cnt_q} + (CNT_W+1)'(1)) != WIDTH_C) werr_d = 1'b1;
      state_d = (line_inc == HEIGHT_C) ? ST_DROP : ST_LINE;
    end

    // a new frame always wins over line bookkeeping
    if (vs_rise) begin
      state_d    = ST_SOF;
      pix_cnt_d  = '0;
      line_cnt_d = '0;
      if (((state_q == ST_LINE) || (state_q == ST_DROP)) && (line_cnt_q != HEIGHT_C)) herr_d = 1'b1;
      if (emit) herr_d = 1'b1;
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_s1_q  <= '0;
      de_s1_q    <= 1'b0;
      state_q    <= ST_IDLE;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tuser_q    <= 1'b0;
      tlast_q    <= 1'b0;
      werr_q     <= 1'b0;
      herr_q     <= 1'b0;
    end else begin
      data_s1_q  <= vid_data;
      de_s1_q    <= vid_de;
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tuser_q    <= tuser_d;
      tlast_q    <= tlast_d;
      werr_q     <= werr_d;
      herr_q     <= herr_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign width_err     = werr_q;
  assign height_err    = herr_q;

`ifdef VID_TO_AXIS_STATUS_EN
  logic [CNT_W-1:0] meas_w_q;
  logic [CNT_W-1:0] meas_h_q;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_w_q <= '0;
      meas_h_q <= '0;
    end else begin
      if (eol)     meas_w_q <= sat_inc(pix_cnt_q);
      if (vs_rise) meas_h_q <= line_cnt_q;
    end
  end

  assign meas_width  = meas_w_q;
  assign meas_height = meas_h_q;
`endif

endmodule

// File: tb/tb_vid_to_axis.sv
// tb/tb_vid_to_axis.sv - randomized scoreboard bench for vid_to_axis
module tb_vid_to_axis;

  localparam int   DW     = 8;
  localparam int   W      = 4;
  localparam int   H      = 3;
  localparam logic VS_ACT = 1'b1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] vid_data;
  logic          vid_de;
  logic          vid_vsync;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic          width_err;
  logic          height_err;
`ifdef VID_TO_AXIS_STATUS_EN
  logic [11:0]   meas_width;
  logic [11:0]   meas_height;
`endif

  vid_to_axis #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .VSYNC_POL  (VS_ACT)
  ) dut (
    .pixel_clk     (clk),
    .rst_n         (rst_n),
    .vid_data      (vid_data),
    .vid_de        (vid_de),
    .vid_vsync     (vid_vsync),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .width_err     (width_err),
    .height_err    (height_err)
`ifdef VID_TO_AXIS_STATUS_EN
    ,
    .meas_width    (meas_width),
    .meas_height   (meas_height)
`endif
  );

  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [DW-1:0] d;
    bit            u;
    bit            l;
    int unsigned   stamp;
  } beat_t;

  beat_t         q[$];
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] last_tdata;

  // frame-level reference model
  bit armed, first, exp_werr, exp_herr;
  int lines, exp_mw, exp_mh;

  function automatic void model_reset();
    armed = 0; first = 0; lines = 0;
    exp_werr = 0; exp_herr = 0; exp_mw = 0; exp_mh = 0;
    last_tdata = '0;
    q.delete();
  endfunction

  function automatic void push_beat(input logic [DW-1:0] d, input bit u, input bit l);
    beat_t b;
    b.d = d; b.u = u; b.l = l; b.stamp = edge_cnt + 2;
    q.push_back(b);
  endfunction

  function automatic void line_done(input int len);
    first = 0;
    lines++;
    if (len != W) exp_werr = 1;
    exp_mw = len;
  endfunction

  function automatic void new_frame();
    exp_mh = lines;
    armed = 1; first = 1; lines = 0;
  endfunction

  task automatic drive(input bit de, input logic [DW-1:0] d, input bit vs);
    @(posedge clk);
    #1;
    vid_de    = de;
    vid_data  = d;
    vid_vsync = vs ? VS_ACT : ~VS_ACT;
  endtask

  task automatic vsync_pulse();
    drive(0, '0, 1);
    if (armed && lines > 0 && lines != H) exp_herr = 1;
    new_frame();
    drive(0, '0, 1);
    drive(0, '0, 0);
  endtask

  task automatic send_line(input int len, input int gap);
    bit fwd;
    logic [DW-1:0] d;
    fwd = armed && (lines < H);
    for (int j = 0; j < len; j++) begin
      d = DW'($urandom);
      drive(1, d, 0);
      if (fwd) push_beat(d, first && (j == 0), j == len - 1);
    end
    if (fwd) line_done(len);
    repeat (gap) drive(0, '0, 0);
  endtask

  // vsync rises together with pixel p of a line; the rest of the line opens a new frame
  task automatic send_cut_line(input int len, input int p, input int gap);
    bit fwd;
    logic [DW-1:0] d;
    fwd = armed && (lines < H);
    for (int j = 0; j < len; j++) begin
      d = DW'($urandom);
      drive(1, d, j >= p);
      if (j < p) begin
        if (fwd) push_beat(d, first && (j == 0), 0);
      end else if (j == p) begin
        if (fwd) begin
          push_beat(d, first && (j == 0), 1);
          if (p + 1 != W) exp_werr = 1;
          exp_mw = p + 1;
          exp_herr = 1;
        end
        new_frame();
      end else begin
        push_beat(d, j == p + 1, j == len - 1);
      end
    end
    if (len - p - 1 > 0) line_done(len - p - 1);
    repeat (gap) drive(0, '0, 0);
  endtask

  task automatic check_zero(input string tag);
    logic [DW+4:0] got;
    got = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, width_err, height_err, m_axis_tdata};
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL %s outputs got=%h required=0", tag, got);
    end
`ifdef VID_TO_AXIS_STATUS_EN
    total++;
    if (meas_width !== 12'd0 || meas_height !== 12'd0) begin
      bad++;
      $display("FAIL %s meas got=%0d/%0d required=0/0", tag, meas_width, meas_height);
    end
`endif
  endtask

  task automatic line_with_reset(input int len, input int at);
    bit fwd;
    logic [DW-1:0] d;
    fwd = armed && (lines < H);
    for (int j = 0; j < len; j++) begin
      d = DW'($urandom);
      drive(1, d, 0);
      if (j == at) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("async_reset");
      end else if (j == at + 1) begin
        rst_n = 1'b1;
      end
      if (j < at && fwd) push_beat(d, first && (j == 0), 0);
    end
    drive(0, '0, 0);
  endtask

  task automatic check_status(input string tag);
    repeat (3) drive(0, '0, 0);
    @(negedge clk);
    total++;
    if (width_err !== exp_werr) begin
      bad++;
      $display("FAIL %s width_err got=%0b required=%0b", tag, width_err, exp_werr);
    end
    total++;
    if (height_err !== exp_herr) begin
      bad++;
      $display("FAIL %s height_err got=%0b required=%0b", tag, height_err, exp_herr);
    end
`ifdef VID_TO_AXIS_STATUS_EN
    total++;
    if (meas_width !== 12'(exp_mw) || meas_height !== 12'(exp_mh)) begin
      bad++;
      $display("FAIL %s meas got=%0d/%0d required=%0d/%0d", tag, meas_width, meas_height, exp_mw, exp_mh);
    end
`endif
  endtask

  always @(negedge clk) begin
    beat_t b;
    if (rst_n) begin
      if (m_axis_tvalid) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat tdata=%h tuser=%b tlast=%b cycle=%0d", m_axis_tdata, m_axis_tuser, m_axis_tlast, edge_cnt);
        end else begin
          b = q.pop_front();
          last_tdata = b.d;
          if (m_axis_tdata !== b.d || m_axis_tuser !== b.u || m_axis_tlast !== b.l || edge_cnt != b.stamp) begin
            bad++;
            $display("FAIL beat got tdata=%h tuser=%b tlast=%b cycle=%0d required tdata=%h tuser=%b tlast=%b cycle=%0d",
                     m_axis_tdata, m_axis_tuser, m_axis_tlast, edge_cnt, b.d, b.u, b.l, b.stamp);
          end
        end
      end else begin
        total++;
        if (m_axis_tdata !== last_tdata) begin
          bad++;
          $display("FAIL tdata_hold got=%h required=%h", m_axis_tdata, last_tdata);
        end
        if (q.size() > 0 && q[0].stamp <= edge_cnt) begin
          b = q.pop_front();
          total++;
          bad++;
          $display("FAIL missing_beat got tvalid=0 required tdata=%h at cycle=%0d", b.d, b.stamp);
        end
      end
    end
  end

  initial begin
    int nl;
    vid_de    = 1'b0;
    vid_data  = '0;
    vid_vsync = ~VS_ACT;
    rst_n     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst_n = 1'b1;
    check_status("after_reset");

    send_line(W, 2);
    send_line(W, 2);
    check_status("pre_vsync");

    vsync_pulse();
    repeat (3) send_line(W, 2);
    vsync_pulse();
    check_status("nominal");

    repeat (4) send_line(W, 2);
    vsync_pulse();
    check_status("four_lines");

    send_line(3, 2);
    send_line(W, 2);
    send_line(W, 2);
    vsync_pulse();
    repeat (3) send_line(W, 2);
    vsync_pulse();
    check_status("short_line_sticky");

    repeat (2) send_line(W, 1);
    vsync_pulse();
    check_status("two_lines");

    line_with_reset(6, 2);
    check_status("post_reset");
    send_line(W, 2);
    check_status("no_vsync_after_reset");

    vsync_pulse();
    send_line(W, 2);
    send_cut_line(6, 2, 2);
    send_line(W, 1);
    send_line(W, 1);
    vsync_pulse();
    check_status("midline_vsync");

    vsync_pulse();
    repeat (3) send_line(1, 1);
    vsync_pulse();
    check_status("single_pixel_lines");

    for (int f = 0; f < 8; f++) begin
      nl = int'($urandom_range(0, 5));
      for (int l = 0; l < nl; l++) send_line(int'($urandom_range(1, 6)), int'($urandom_range(1, 3)));
      vsync_pulse();
      check_status("random_frame");
    end

    repeat (4) drive(0, '0, 0);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL leftover_beats got=%0d required=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
